scroll_bg_renderer: RTL and testbench

- Parametrised full-screen background renderer with per-frame vertical scrolling and wrap-around.
- Replaces the fixed 320x240, stretch-to-640x480 background ROM examples.
- Image size, power-of-two scale and palette width are parameters.
- The index ROM and palette are external; a registered pipeline drives them, and blank is delay-matched through it.
- Sits between the VGA controller (DrawX/DrawY/blank/vs) and the colour mux feeding the DAC.

---
 rtl/scroll_bg_renderer_if.sv | 53 +++++
 rtl/scroll_bg_renderer.sv | 112 +++++++++++
 tb/tb_scroll_bg_renderer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/scroll_bg_renderer_if.sv
// Bundle between the VGA controller / index ROM / palette side (master)
// and the background renderer (slave).
interface scroll_bg_renderer_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned SPD_W  = 8
) ();
    // Beam position and timing from the VGA controller
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic              vs;

    // Scroll control
    logic              scroll_en;
    logic              scroll_dir;
    logic [SPD_W-1:0]  scroll_spd;

    // External index ROM and palette
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q;
    logic [IDX_W-1:0]  pal_index;
    logic [3:0]        pal_red;
    logic [3:0]        pal_green;
    logic [3:0]        pal_blue;

    // Colour to the DAC mux, plus scroll status
    logic [3:0]        red;
    logic [3:0]        green;
    logic [3:0]        blue;
    logic [ADDR_W-1:0] y_offset;
    logic              frame_tick;

    modport master (
        output DrawX, DrawY, blank, vs,
        output scroll_en, scroll_dir, scroll_spd,
        input  rom_address,
        output rom_q,
        input  pal_index,
        output pal_red, pal_green, pal_blue,
        input  red, green, blue, y_offset, frame_tick
    );

    modport slave (
        input  DrawX, DrawY, blank, vs,
        input  scroll_en, scroll_dir, scroll_spd,
        output rom_address,
        input  rom_q,
        output pal_index,
        input  pal_red, pal_green, pal_blue,
        output red, green, blue, y_offset, frame_tick
    );
endinterface

// File: rtl/scroll_bg_renderer.sv
// Full-screen background renderer: maps the beam to a vertically scrolled image
// address, drives the external index ROM and palette, and registers the colour.
module scroll_bg_renderer #(
    parameter int unsigned IMG_W    = 320,
    parameter int unsigned IMG_H    = 240,
    parameter int unsigned SCALE_SH = 1,
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned SPD_W    = 8
) (
    input logic            vga_clk,
    input logic            reset_n,
    scroll_bg_renderer_if.slave io_vga
);
    localparam int unsigned OW = ADDR_W + 1;
    localparam logic signed [OW-1:0] IMG_H_S = OW'(IMG_H);

    // Pipeline and scroll state
    logic [ADDR_W-1:0] r_rom_address;
    logic              r_v1;
    logic [IDX_W-1:0]  r_pal_index;
    logic              r_v2;
    logic [3:0]        r_red;
    logic [3:0]        r_green;
    logic [3:0]        r_blue;
    logic [ADDR_W-1:0] r_y_offset;
    logic              r_frame_tick;
    logic              r_vs_d;

    // Stage-0 coordinate map
    logic [9:0]        w_col;
    logic [9:0]        w_srow;
    logic              w_inside;
    logic [31:0]       w_row_sum;
    logic [31:0]       w_row;
    logic [ADDR_W-1:0] w_addr;

    // Frame-boundary offset update
    logic                 w_fe;
    logic signed [OW-1:0] w_off_s;
    logic signed [OW-1:0] w_spd_s;
    logic signed [OW-1:0] w_step;
    logic signed [OW-1:0] w_next;

    always_comb begin
        w_col     = io_vga.DrawX >> SCALE_SH;
        w_srow    = io_vga.DrawY >> SCALE_SH;
        w_inside  = (32'(w_col) < IMG_W) && (32'(w_srow) < IMG_H);
        // Both terms are below IMG_H for in-image rows, so one subtraction wraps.
        w_row_sum = 32'(w_srow) + 32'(r_y_offset);
        w_row     = (w_row_sum >= IMG_H) ? (w_row_sum - IMG_H) : w_row_sum;
        w_addr    = ADDR_W'(w_row * IMG_W + 32'(w_col));
    end

    always_comb begin
        w_fe    = r_vs_d & ~io_vga.vs;
        w_off_s = $signed({1'b0, r_y_offset});
        w_spd_s = $signed(OW'(io_vga.scroll_spd));
        w_step  = w_off_s;
        w_next  = w_off_s;
        if (io_vga.scroll_dir) begin
            w_step = w_off_s + w_spd_s;
            w_next = (w_step >= IMG_H_S) ? (w_step - IMG_H_S) : w_step;
        end else begin
            w_step = w_off_s - w_spd_s;
            w_next = w_step[OW-1] ? (w_step + IMG_H_S) : w_step;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_rom_address <= '0;
            r_v1          <= 1'b0;
            r_pal_index   <= '0;
            r_v2          <= 1'b0;
            r_red         <= 4'd0;
            r_green       <= 4'd0;
            r_blue        <= 4'd0;
            r_y_offset    <= '0;
            r_frame_tick  <= 1'b0;
            r_vs_d        <= 1'b1;
        end else begin
            r_rom_address <= w_addr;
            r_v1          <= io_vga.blank & w_inside;
            r_pal_index   <= io_vga.rom_q;
            r_v2          <= r_v1;
            if (r_v2) begin
                r_red   <= io_vga.pal_red;
                r_green <= io_vga.pal_green;
                r_blue  <= io_vga.pal_blue;
            end else begin
                r_red   <= 4'd0;
                r_green <= 4'd0;
                r_blue  <= 4'd0;
            end
            r_vs_d       <= io_vga.vs;
            r_frame_tick <= w_fe;
            // Offset only moves on the vs falling edge, so a frame never tears.
            if (w_fe && io_vga.scroll_en) begin
                r_y_offset <= ADDR_W'(w_next);
            end
        end
    end

    assign io_vga.rom_address = r_rom_address;
    assign io_vga.pal_index   = r_pal_index;
    assign io_vga.red         = r_red;
    assign io_vga.green       = r_green;
    assign io_vga.blue        = r_blue;
    assign io_vga.y_offset    = r_y_offset;
    assign io_vga.frame_tick  = r_frame_tick;
endmodule

// File: tb/tb_scroll_bg_renderer.sv
// Scoreboard bench for scroll_bg_renderer: a 320x240 default instance and a
// 200x150 instance share the beam/scroll stimulus, each with its own ROM/palette.
module tb_scroll_bg_renderer;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    scroll_bg_renderer_if #(.ADDR_W(17), .IDX_W(4), .SPD_W(8)) if1 ();
    scroll_bg_renderer_if #(.ADDR_W(15), .IDX_W(4), .SPD_W(8)) if2 ();

    scroll_bg_renderer #(
        .IMG_W(320), .IMG_H(240), .SCALE_SH(1), .ADDR_W(17), .IDX_W(4), .SPD_W(8)
    ) u_dut1 (
        .vga_clk (clk),
        .reset_n (reset_n),
        .io_vga  (if1)
    );

    scroll_bg_renderer #(
        .IMG_W(200), .IMG_H(150), .SCALE_SH(1), .ADDR_W(15), .IDX_W(4), .SPD_W(8)
    ) u_dut2 (
        .vga_clk (clk),
        .reset_n (reset_n),
        .io_vga  (if2)
    );

    function automatic logic [3:0] rom_f(input logic [31:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12];
    endfunction

    function automatic logic [11:0] pal_f(input logic [3:0] i);
        return {i, ~i, i + 4'd5};
    endfunction

    // Combinational ROM from the registered address, combinational palette
    assign if1.rom_q = rom_f(32'(if1.rom_address));
    assign if2.rom_q = rom_f(32'(if2.rom_address));
    assign {if1.pal_red, if1.pal_green, if1.pal_blue} = pal_f(if1.pal_index);
    assign {if2.pal_red, if2.pal_green, if2.pal_blue} = pal_f(if2.pal_index);

    assign if2.DrawX      = if1.DrawX;
    assign if2.DrawY      = if1.DrawY;
    assign if2.blank      = if1.blank;
    assign if2.vs         = if1.vs;
    assign if2.scroll_en  = if1.scroll_en;
    assign if2.scroll_dir = if1.scroll_dir;
    assign if2.scroll_spd = if1.scroll_spd;

    function automatic int exp_addr(int x, int y, int off, int w, int h, int aw);
        int col = x >> 1;
        int row = (y >> 1) + off;
        if (row >= h) row -= h;
        return (row * w + col) & ((1 << aw) - 1);
    endfunction

    function automatic logic [11:0] exp_rgb(int x, int y, bit bl, int off, int w, int h,
                                            int aw);
        if (bl && ((x >> 1) < w) && ((y >> 1) < h))
            return pal_f(rom_f(32'(exp_addr(x, y, off, w, h, aw))));
        return 12'd0;
    endfunction

    function automatic int next_off(int off, int spd, bit dir, int h);
        int n;
        if (dir) begin
            n = off + spd;
            if (n >= h) n -= h;
        end else begin
            n = off - spd;
            if (n < 0) n += h;
        end
        return n;
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [11:0] q1[$];
    logic [11:0] q2[$];
    int m_off1, m_off2;
    bit m_vs_d;
    int ticks_seen, ticks_exp;

    task automatic set_scroll(input bit en, input bit dir, input int spd);
        if1.scroll_en  = en;
        if1.scroll_dir = dir;
        if1.scroll_spd = 8'(spd);
    endtask

    task automatic step(input int x, input int y, input bit bl, input bit v);
        int a1, a2;
        bit fe;
        if1.DrawX = 10'(x);
        if1.DrawY = 10'(y);
        if1.blank = bl;
        if1.vs    = v;
        a1 = exp_addr(x, y, m_off1, 320, 240, 17);
        a2 = exp_addr(x, y, m_off2, 200, 150, 15);
        q1.push_back(exp_rgb(x, y, bl, m_off1, 320, 240, 17));
        q2.push_back(exp_rgb(x, y, bl, m_off2, 200, 150, 15));
        fe = m_vs_d && !v;
        @(posedge clk);
        #1;
        if (fe) begin
            ticks_exp++;
            if (if1.scroll_en) begin
                m_off1 = next_off(m_off1, int'(if1.scroll_spd), if1.scroll_dir, 240);
                m_off2 = next_off(m_off2, int'(if1.scroll_spd), if1.scroll_dir, 150);
            end
        end
        m_vs_d = v;
        if (if1.frame_tick) ticks_seen++;
        check("addr1", 32'(if1.rom_address), 32'(a1));
        check("addr2", 32'(if2.rom_address), 32'(a2));
        if (((x >> 1) < 200) && ((y >> 1) < 150))
            check("addr2_range", 32'(if2.rom_address < 15'd30000), 32'd1);
        check("yoff1", 32'(if1.y_offset), 32'(m_off1));
        check("yoff2", 32'(if2.y_offset), 32'(m_off2));
        check("tick1", 32'(if1.frame_tick), 32'(fe));
        check("tick2", 32'(if2.frame_tick), 32'(fe));
        if (q1.size() >= 3) check("rgb1", 32'({if1.red, if1.green, if1.blue}), 32'(q1.pop_front()));
        if (q2.size() >= 3) check("rgb2", 32'({if2.red, if2.green, if2.blue}), 32'(q2.pop_front()));
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        if1.vs   = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rgb1", 32'({if1.red, if1.green, if1.blue}), 32'd0);
        check("rst_rgb2", 32'({if2.red, if2.green, if2.blue}), 32'd0);
        check("rst_addr", 32'(if1.rom_address), 32'd0);
        check("rst_pal", 32'(if1.pal_index), 32'd0);
        check("rst_yoff", 32'(if1.y_offset), 32'd0);
        check("rst_tick", 32'(if1.frame_tick), 32'd0);
        reset_n = 1'b1;
        m_off1  = 0;
        m_off2  = 0;
        m_vs_d  = 1'b1;
        q1.delete();
        q2.delete();
        // Two emptied pipeline stages still ahead of the first new pixel
        repeat (2) begin
            q1.push_back(12'd0);
            q2.push_back(12'd0);
        end
    endtask

    task automatic frame(input int lo);
        repeat (lo) step(0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(i * 83, i * 61, 1'b1, 1'b1);
    endtask

    int t0;

    initial begin
        reset_n   = 1'b0;
        if1.DrawX = '0;
        if1.DrawY = '0;
        if1.blank = 1'b0;
        if1.vs    = 1'b1;
        set_scroll(1'b0, 1'b1, 0);
        ticks_seen = 0;
        ticks_exp  = 0;
        do_reset();

        // Unscrolled sweep, a blanked line, and the small instance's image edge
        for (int y = 0; y < 480; y += 29)
            for (int x = 0; x < 640; x += 5) step(x, y, 1'b1, 1'b1);
        for (int x = 0; x < 640; x += 7) step(x, 100, 1'b0, 1'b1);
        for (int y = 296; y < 304; y++)
            for (int x = 390; x < 410; x++) step(x, y, 1'b1, 1'b1);
        step(5, 7, 1'b1, 1'b1);
        check("addr_5_7", 32'(if1.rom_address), 32'd962);

        // Five frames of upward scroll; vs held low for 2 cycles must not retrigger
        set_scroll(1'b1, 1'b1, 10);
        t0 = ticks_seen;
        repeat (5) frame(2);
        check("yoff_50", 32'(if1.y_offset), 32'd50);
        check("ticks_5", 32'(ticks_seen - t0), 32'd5);
        step(0, 0, 1'b1, 1'b1);
        check("addr_row50", 32'(if1.rom_address), 32'd16000);

        // Wrap upward, then downward
        repeat (18) frame(1);
        set_scroll(1'b1, 1'b1, 5);
        frame(1);
        check("yoff_235", 32'(if1.y_offset), 32'd235);
        set_scroll(1'b1, 1'b1, 10);
        frame(1);
        check("yoff_wrap_up", 32'(if1.y_offset), 32'd5);
        step(0, 478, 1'b1, 1'b1);
        check("addr_row4", 32'(if1.rom_address), 32'd1280);
        set_scroll(1'b1, 1'b0, 2);
        frame(1);
        check("yoff_3", 32'(if1.y_offset), 32'd3);
        set_scroll(1'b1, 1'b0, 10);
        frame(1);
        check("yoff_wrap_dn", 32'(if1.y_offset), 32'd233);

        // Zero speed and disabled scroll: offset holds, ticks continue
        set_scroll(1'b1, 1'b1, 0);
        t0 = ticks_seen;
        repeat (3) frame(1);
        check("yoff_spd0", 32'(if1.y_offset), 32'd233);
        set_scroll(1'b0, 1'b1, 20);
        repeat (3) frame(3);
        check("yoff_dis", 32'(if1.y_offset), 32'd233);
        check("ticks_6", 32'(ticks_seen - t0), 32'd6);

        // Mid-frame reset at offset 100
        set_scroll(1'b1, 1'b1, 107);
        frame(1);
        check("yoff_100", 32'(if1.y_offset), 32'd100);
        for (int x = 0; x < 40; x++) step(x * 4, 200, 1'b1, 1'b1);
        set_scroll(1'b0, 1'b1, 0);
        do_reset();
        for (int x = 0; x < 60; x++) step(x * 4, 202, 1'b1, 1'b1);
        check("ticks_total", 32'(ticks_seen), 32'(ticks_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
